// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use hazard detection and flush squash.
// Latency: one cycle ID->EX; stall_id is combinational from the current EX contents.
// Backpressure: load-use hazard raises stall_id and inserts one bubble; flush overrides the stall.
module id_ex_stage #(
    parameter int XLEN     = 64,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [XLEN-1:0]     id_rd1,
    input  logic [XLEN-1:0]     id_rd2,
    input  logic [REG_ADDR-1:0] id_rs1,
    input  logic [REG_ADDR-1:0] id_rs2,
    input  logic [REG_ADDR-1:0] id_rd,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [8:0]          id_ctrl,
    input  logic                wb_regwrite,
    input  logic [REG_ADDR-1:0] wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic                stall_id,
    output logic                ex_valid,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_op1,
    output logic [XLEN-1:0]     ex_op2,
    output logic [XLEN-1:0]     ex_imm,
    output logic [REG_ADDR-1:0] ex_rs1,
    output logic [REG_ADDR-1:0] ex_rs2,
    output logic [REG_ADDR-1:0] ex_rd,
    output logic [8:0]          ex_ctrl
);

    // ctrl = {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,ALUOp[1:0],Jump}
    localparam int CTRL_MEMREAD = 7;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            wb_fwd;
    logic            hz;

    // The file writes on the same edge we capture, so its read port still shows the old value.
    assign wb_fwd = wb_regwrite && (wb_rd != '0);
    assign op1    = (wb_fwd && (wb_rd == id_rs1)) ? wb_data : id_rd1;
    assign op2    = (wb_fwd && (wb_rd == id_rs2)) ? wb_data : id_rd2;

    assign hz = id_valid && ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign stall_id = hz && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_imm   <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_ctrl  <= '0;
        end else if (flush || hz) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_imm   <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_pc    <= id_pc;
            ex_op1   <= op1;
            ex_op2   <= op2;
            ex_imm   <= id_imm;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
            ex_ctrl  <= id_valid ? id_ctrl : 9'd0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expected EX contents are queued at drive time and checked after each edge.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [8:0]  ctrl;
    } ex_t;

    localparam logic [8:0] C_ALU = 9'h104;
    localparam logic [8:0] C_LD  = 9'h1B0;
    localparam logic [8:0] C_SW  = 9'h050;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [63:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [8:0]  id_ctrl;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;
    logic        stall_id;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [8:0]  ex_ctrl;

    ex_t exp_q[$];
    int  vectors    = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1),
        .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
    );

    function automatic ex_t mk(input logic v, input logic [63:0] pc, o1, o2, imm,
                               input logic [4:0] r1, r2, rd, input logic [8:0] c);
        ex_t e;
        e.valid = v; e.pc = pc; e.op1 = o1; e.op2 = o2; e.imm = imm;
        e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.ctrl = c;
        return e;
    endfunction

    task automatic drive_id(input logic v, input logic [63:0] pc, rd1, rd2, imm,
                            input logic [4:0] r1, r2, rd, input logic [8:0] c);
        id_valid = v; id_pc = pc; id_rd1 = rd1; id_rd2 = rd2; id_imm = imm;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_ctrl = c;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] r, input logic [63:0] d);
        wb_regwrite = we; wb_rd = r; wb_data = d;
    endtask

    task automatic check_out(input string tag);
        ex_t got, want;
        got = {ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed output with empty scoreboard", tag);
        end else begin
            want = exp_q.pop_front();
            assert (got === want) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic check_stall(input string tag, input logic want);
        #1;
        vectors++;
        assert (stall_id === want) else begin
            miscompares++;
            $error("FAIL %s: stall_id observed %b expected %b", tag, stall_id, want);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        drive_wb(1'b0, 5'd0, 64'd0);
        drive_id(1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 9'd0);

        // T1: everything toggling under reset
        for (int i = 0; i < 4; i++) begin
            drive_id(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, 5'($urandom), 5'($urandom), 5'($urandom), 9'($urandom));
            drive_wb(1'($urandom), 5'($urandom), {$urandom, $urandom});
            flush = 1'($urandom);
            exp_q.push_back('0);
            check_stall("rst_stall", 1'b0);
            step("rst_out");
        end

        reset = 1'b1;
        flush = 1'b0;
        drive_wb(1'b0, 5'd0, 64'd0);
        drive_id(1'b1, 64'h1000, 64'h11, 64'h22, 64'h4, 5'd1, 5'd2, 5'd3, C_ALU);
        exp_q.push_back(mk(1'b1, 64'h1000, 64'h11, 64'h22, 64'h4, 5'd1, 5'd2, 5'd3, C_ALU));
        check_stall("rel_stall", 1'b0);
        step("first_capture");

        // T2: write-back bypass cases
        drive_id(1'b1, 64'h1004, 64'h7, 64'h33, 64'h0, 5'd5, 5'd8, 5'd9, C_ALU);
        drive_wb(1'b1, 5'd5, 64'hAA);
        exp_q.push_back(mk(1'b1, 64'h1004, 64'hAA, 64'h33, 64'h0, 5'd5, 5'd8, 5'd9, C_ALU));
        check_stall("byp1_stall", 1'b0);
        step("byp_op1");

        drive_id(1'b1, 64'h1008, 64'h7, 64'h33, 64'h0, 5'd0, 5'd8, 5'd9, C_ALU);
        drive_wb(1'b1, 5'd0, 64'hAA);
        exp_q.push_back(mk(1'b1, 64'h1008, 64'h7, 64'h33, 64'h0, 5'd0, 5'd8, 5'd9, C_ALU));
        step("byp_x0");

        drive_id(1'b1, 64'h100C, 64'h44, 64'h55, 64'h8, 5'd4, 5'd9, 5'd10, C_ALU);
        drive_wb(1'b1, 5'd9, 64'hBB);
        exp_q.push_back(mk(1'b1, 64'h100C, 64'h44, 64'hBB, 64'h8, 5'd4, 5'd9, 5'd10, C_ALU));
        step("byp_op2");

        drive_wb(1'b0, 5'd9, 64'hCC);
        exp_q.push_back(mk(1'b1, 64'h100C, 64'h44, 64'h55, 64'h8, 5'd4, 5'd9, 5'd10, C_ALU));
        step("byp_noregwr");

        // T3: load-use stall, one bubble, then the add is captured
        drive_id(1'b1, 64'h2000, 64'h100, 64'h0, 64'h10, 5'd2, 5'd0, 5'd6, C_LD);
        exp_q.push_back(mk(1'b1, 64'h2000, 64'h100, 64'h0, 64'h10, 5'd2, 5'd0, 5'd6, C_LD));
        step("ld_capture");

        drive_id(1'b1, 64'h2004, 64'h3, 64'h66, 64'h0, 5'd3, 5'd6, 5'd7, C_ALU);
        exp_q.push_back('0);
        check_stall("lu_stall", 1'b1);
        step("lu_bubble");

        exp_q.push_back(mk(1'b1, 64'h2004, 64'h3, 64'h66, 64'h0, 5'd3, 5'd6, 5'd7, C_ALU));
        check_stall("lu_release", 1'b0);
        step("lu_add");

        // T4: flush beats the hazard
        drive_id(1'b1, 64'h3000, 64'h200, 64'h0, 64'h20, 5'd2, 5'd0, 5'd6, C_LD);
        exp_q.push_back(mk(1'b1, 64'h3000, 64'h200, 64'h0, 64'h20, 5'd2, 5'd0, 5'd6, C_LD));
        step("ld2_capture");

        drive_id(1'b1, 64'h3004, 64'h9, 64'hA, 64'h0, 5'd6, 5'd1, 5'd7, C_ALU);
        flush = 1'b1;
        exp_q.push_back('0);
        check_stall("flush_stall", 1'b0);
        step("flush_bubble");
        flush = 1'b0;

        // Invalid decode slot and x0 destination never stall
        drive_id(1'b1, 64'h3100, 64'h1, 64'h0, 64'h0, 5'd2, 5'd0, 5'd6, C_LD);
        exp_q.push_back(mk(1'b1, 64'h3100, 64'h1, 64'h0, 64'h0, 5'd2, 5'd0, 5'd6, C_LD));
        step("ld3_capture");

        drive_id(1'b0, 64'h3104, 64'h5, 64'h6, 64'h7, 5'd6, 5'd6, 5'd8, C_ALU);
        exp_q.push_back(mk(1'b0, 64'h3104, 64'h5, 64'h6, 64'h7, 5'd6, 5'd6, 5'd8, 9'd0));
        check_stall("inv_stall", 1'b0);
        step("inv_capture");

        drive_id(1'b1, 64'h3200, 64'h1, 64'h0, 64'h0, 5'd2, 5'd0, 5'd0, C_LD);
        exp_q.push_back(mk(1'b1, 64'h3200, 64'h1, 64'h0, 64'h0, 5'd2, 5'd0, 5'd0, C_LD));
        step("ldx0_capture");

        drive_id(1'b1, 64'h3204, 64'h5, 64'h6, 64'h0, 5'd0, 5'd3, 5'd4, C_ALU);
        exp_q.push_back(mk(1'b1, 64'h3204, 64'h5, 64'h6, 64'h0, 5'd0, 5'd3, 5'd4, C_ALU));
        check_stall("x0_stall", 1'b0);
        step("x0_capture");

        // T5: store in EX does not stall a dependent read
        drive_id(1'b1, 64'h4000, 64'h8, 64'h9, 64'h18, 5'd1, 5'd2, 5'd6, C_SW);
        exp_q.push_back(mk(1'b1, 64'h4000, 64'h8, 64'h9, 64'h18, 5'd1, 5'd2, 5'd6, C_SW));
        step("sw_capture");

        drive_id(1'b1, 64'h4004, 64'hE, 64'hF, 64'h0, 5'd6, 5'd3, 5'd11, C_ALU);
        exp_q.push_back(mk(1'b1, 64'h4004, 64'hE, 64'hF, 64'h0, 5'd6, 5'd3, 5'd11, C_ALU));
        check_stall("sw_stall", 1'b0);
        step("sw_dep_capture");

        // T6: back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            drive_id(1'b1, 64'h5000 + 64'(4 * i), 64'h100 + 64'(i), 64'h200 + 64'(i), 64'(i),
                     5'(10 + i), 5'(20 + i), 5'(11 + i), C_ALU);
            exp_q.push_back(mk(1'b1, 64'h5000 + 64'(4 * i), 64'h100 + 64'(i), 64'h200 + 64'(i),
                               64'(i), 5'(10 + i), 5'(20 + i), 5'(11 + i), C_ALU));
            check_stall("b2b_stall", 1'b0);
            step("b2b_capture");
        end

        // Reset asserted while stalled: bubble is lost, stage empty afterwards
        drive_id(1'b1, 64'h6000, 64'h1, 64'h0, 64'h0, 5'd2, 5'd0, 5'd6, C_LD);
        exp_q.push_back(mk(1'b1, 64'h6000, 64'h1, 64'h0, 64'h0, 5'd2, 5'd0, 5'd6, C_LD));
        step("ld4_capture");

        drive_id(1'b1, 64'h6004, 64'h3, 64'h4, 64'h0, 5'd6, 5'd1, 5'd7, C_ALU);
        check_stall("mid_stall", 1'b1);
        reset = 1'b0;
        exp_q.push_back('0);
        #1;
        check_out("async_rst");
        check_stall("rst_nostall", 1'b0);
        exp_q.push_back('0);
        step("rst_hold");

        reset = 1'b1;
        drive_id(1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0, 9'd0);
        exp_q.push_back('0);
        step("post_rst_empty");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
